// File: rtl/proc_trace_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_trace_pkg
// Brief    : Shared types for the processor trace capture buffer: FSM state
//            encoding and the stored trace entry layout.
//            Optional macro: PROC_TRACE_TSTAMP_EN adds a 32-bit cycle stamp.
// Revision : 1.0 - initial release
// ============================================================================
package proc_trace_pkg;

    localparam logic [1:0] c_STATE_IDLE    = 2'd0;
    localparam logic [1:0] c_STATE_ARMED   = 2'd1;
    localparam logic [1:0] c_STATE_CAPTURE = 2'd2;
    localparam logic [1:0] c_STATE_DONE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = c_STATE_IDLE,
        ST_ARMED   = c_STATE_ARMED,
        ST_CAPTURE = c_STATE_CAPTURE,
        ST_DONE    = c_STATE_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
`ifdef PROC_TRACE_TSTAMP_EN
        logic [31:0] tstamp;
`endif
    } trace_entry_t;

    localparam int c_ENTRY_W = $bits(trace_entry_t);

endpackage
`default_nettype wire

// File: rtl/proc_trace_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : proc_trace_fifo
// Brief    : Circular FIFO with power-of-two depth. Owns storage, pointers,
//            occupancy count and the full/empty decisions.
// Revision : 1.0 - initial release
// ============================================================================
module proc_trace_fifo #(
    parameter int  DEPTH   = 16,
    parameter type ENTRY_T = logic [63:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  ENTRY_T                 push_entry,
    input  logic                   pop,
    output logic                   head_val,
    output ENTRY_T                 head_entry,
    output logic [$clog2(DEPTH):0] count,
    output logic                   push_drop
);

    localparam int                  c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]    c_FULL    = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]    c_CNT_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE = c_PTR_W'(1);

    ENTRY_T               r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);

    // Clear wins over everything; a pop frees a slot for a push into a full FIFO.
    assign w_pop     = pop && !w_empty && !clear;
    assign w_push    = push && !clear && (!w_full || w_pop);
    assign push_drop = push && !clear && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    // Storage is uninitialised after reset, so the head is forced to zero when empty.
    assign head_val   = !w_empty;
    assign head_entry = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/proc_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : proc_trace_buffer
// Brief    : Trace capture buffer: arm/trigger/stop FSM in front of a drainable
//            FIFO. Optional macro PROC_TRACE_TSTAMP_EN adds per-entry stamps.
// Revision : 1.0 - initial release
// ============================================================================
module proc_trace_buffer
    import proc_trace_pkg::*;
#(
    parameter int p_depth = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_val,
    input  logic [31:0]              trace_addr,
    input  logic [31:0]              trace_data,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     clear,
    input  logic [31:0]              trig_addr,
    output logic                     drain_val,
    input  logic                     drain_rdy,
    output logic [31:0]              drain_addr,
    output logic [31:0]              drain_data,
`ifdef PROC_TRACE_TSTAMP_EN
    output logic [31:0]              drain_tstamp,
`endif
    output logic [1:0]               state,
    output logic [$clog2(p_depth):0] count,
    output logic                     overflow
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_push_req;
    logic         w_trig_hit;
    logic         w_push_drop;
    logic         r_overflow;
    trace_entry_t w_push_entry;
    trace_entry_t w_head_entry;

`ifdef PROC_TRACE_TSTAMP_EN
    logic [31:0]  r_tstamp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tstamp <= '0;
        end else begin
            r_tstamp <= r_tstamp + 32'd1;
        end
    end
`endif

    assign w_trig_hit = trace_val && (trace_addr == trig_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // arm and stop are only meaningful in their own states, so they never collide.
    always_comb begin
        w_state_nxt = r_state;
        w_push_req  = 1'b0;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        w_state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_trig_hit) begin
                        w_push_req  = 1'b1;
                        w_state_nxt = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    w_push_req = trace_val;
                    if (stop) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (arm) begin
                        w_state_nxt = ST_ARMED;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_overflow <= 1'b0;
        end else if (w_push_drop) begin
            r_overflow <= 1'b1;
        end
    end

    always_comb begin
        w_push_entry        = '0;
        w_push_entry.addr   = trace_addr;
        w_push_entry.data   = trace_data;
`ifdef PROC_TRACE_TSTAMP_EN
        w_push_entry.tstamp = r_tstamp;
`endif
    end

    proc_trace_fifo #(
        .DEPTH   (p_depth),
        .ENTRY_T (trace_entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .push       (w_push_req),
        .push_entry (w_push_entry),
        .pop        (drain_rdy),
        .head_val   (drain_val),
        .head_entry (w_head_entry),
        .count      (count),
        .push_drop  (w_push_drop)
    );

    assign drain_addr   = w_head_entry.addr;
    assign drain_data   = w_head_entry.data;
`ifdef PROC_TRACE_TSTAMP_EN
    assign drain_tstamp = w_head_entry.tstamp;
`endif
    assign state        = r_state;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_proc_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_trace_buffer
// Brief    : Scoreboard bench for proc_trace_buffer (depth 4) against a
//            queue-based reference model; honours PROC_TRACE_TSTAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_trace_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trace_val = 1'b0;
    logic [31:0]   trace_addr = '0;
    logic [31:0]   trace_data = '0;
    logic          arm = 1'b0;
    logic          stop = 1'b0;
    logic          clear = 1'b0;
    logic [31:0]   trig_addr = 32'h200;
    logic          drain_val;
    logic          drain_rdy = 1'b0;
    logic [31:0]   drain_addr;
    logic [31:0]   drain_data;
    logic [31:0]   drain_tstamp;
    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          overflow;

    always #5 clk = ~clk;

`ifndef PROC_TRACE_TSTAMP_EN
    assign drain_tstamp = '0;
`endif

    proc_trace_buffer #(.p_depth(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .trace_val    (trace_val),
        .trace_addr   (trace_addr),
        .trace_data   (trace_data),
        .arm          (arm),
        .stop         (stop),
        .clear        (clear),
        .trig_addr    (trig_addr),
        .drain_val    (drain_val),
        .drain_rdy    (drain_rdy),
        .drain_addr   (drain_addr),
        .drain_data   (drain_data),
`ifdef PROC_TRACE_TSTAMP_EN
        .drain_tstamp (drain_tstamp),
`endif
        .state        (state),
        .count        (count),
        .overflow     (overflow)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] ts;
    } exp_t;

    exp_t        model_q[$];
    exp_t        sb_q[$];
    int          m_state = 0;
    int          m_ovf   = 0;
    logic [31:0] m_cyc   = '0;
    int          cur_state = 0, cur_count = 0, cur_ovf = 0, cur_val = 0;
    bit          in_reset = 1'b1;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of inputs and advances the model to what the next edge should produce.
    task automatic drive(logic tv, logic [31:0] ta, logic [31:0] td,
                         logic a, logic s, logic c, logic r);
        bit pop, hit;
        trace_val  = tv;
        trace_addr = ta;
        trace_data = td;
        arm        = a;
        stop       = s;
        clear      = c;
        drain_rdy  = r;
        cur_state  = m_state;
        cur_count  = model_q.size();
        cur_ovf    = m_ovf;
        cur_val    = (model_q.size() != 0) ? 1 : 0;
        pop = (model_q.size() != 0) && r;
        if (c) begin
            model_q.delete();
            m_ovf   = 0;
            m_state = 0;
        end else begin
            hit = tv && ((m_state == 2) || (m_state == 1 && ta == trig_addr));
            if (pop) sb_q.push_back(model_q.pop_front());
            if (hit) begin
                if (model_q.size() < DEPTH) model_q.push_back('{ta, td, m_cyc});
                else m_ovf = 1;
            end
            case (m_state)
                0: if (a) m_state = 1;
                1: if (hit) m_state = 2;
                2: if (s) m_state = 3;
                default: if (a) m_state = 1;
            endcase
        end
        m_cyc = m_cyc + 32'd1;
    endtask

    task automatic cyc(logic tv, logic [31:0] ta, logic [31:0] td,
                       logic a, logic s, logic c, logic r);
        @(posedge clk);
        #1;
        drive(tv, ta, td, a, s, c, r);
    endtask

    task automatic idle(int n, logic r);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, r);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_drain_val"},  32'(drain_val), 32'h0);
        chk({tag, "_drain_addr"}, drain_addr, 32'h0);
        chk({tag, "_drain_data"}, drain_data, 32'h0);
        chk({tag, "_drain_ts"},   drain_tstamp, 32'h0);
        chk({tag, "_state"},      32'(state), 32'h0);
        chk({tag, "_count"},      32'(count), 32'h0);
        chk({tag, "_overflow"},   32'(overflow), 32'h0);
    endtask

    task automatic release_reset();
        model_q.delete();
        sb_q.delete();
        m_state = 0;
        m_ovf   = 0;
        m_cyc   = '0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: status every cycle, and each accepted drain entry against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                chk("state",     32'(state),     32'(cur_state));
                chk("count",     32'(count),     32'(cur_count));
                chk("overflow",  32'(overflow),  32'(cur_ovf));
                chk("drain_val", 32'(drain_val), 32'(cur_val));
                if (drain_val && drain_rdy && !clear) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pop actual=0x%0h required=none at %0t", drain_addr, $time);
                    end else begin
                        e = sb_q.pop_front();
                        chk("drain_addr", drain_addr, e.addr);
                        chk("drain_data", drain_data, e.data);
`ifdef PROC_TRACE_TSTAMP_EN
                        chk("drain_tstamp", drain_tstamp, e.ts);
`endif
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] addrs [4];
        addrs[0] = 32'h1FC; addrs[1] = 32'h200; addrs[2] = 32'h204; addrs[3] = 32'h300;

        #12;
        check_reset_outputs("por");
        release_reset();

        // Trigger: only the matching PC starts capture.
        idle(2, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1FC, 32'hA000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h200, 32'hA000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 32'hA000_0003, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Overflow: six beats into four slots with no draining.
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 32'h400 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        idle(5, 1'b1);

        // Push into a full FIFO while popping.
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h200, 32'hC000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++)
            cyc(1'b1, 32'h500 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h5F0, 32'hC000_00FF, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        idle(5, 1'b1);

        // Stop: the stop-cycle beat is kept, the next is not.
        cyc(1'b1, 32'h300, 32'hD000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h304, 32'hD000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        idle(2, 1'b1);

        // Clear with a push and a pop in the same cycle.
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h200, 32'hE000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 32'hE000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h208, 32'hE000_0002, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Reset in the middle of a capture.
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h200, 32'hF000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 32'hF000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        in_reset = 1'b1;
        rst      = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        release_reset();

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) != 0,
                addrs[$urandom % 4] + (($urandom % 4 == 0) ? 32'h10 : 32'h0),
                $urandom,
                ($urandom % 8) == 0,
                ($urandom % 16) == 0,
                ($urandom % 40) == 0,
                ($urandom % 2) == 0);
        end
        idle(DEPTH + 2, 1'b1);
        @(posedge clk);
        #1;
        chk("sb_leftover", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
